aes_block_fetch_ctrl: RTL and testbench



---
 rtl/aes_block_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_aes_block_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_fetch_ctrl.sv
// aes_block_fetch_ctrl
// Walks ROM addresses 0..last after a start pulse. Each plaintext/key pair is
// registered and offered to the AES core over a valid/ready handshake, and a
// one-cycle done pulse marks the end of the run.
// Optional feature macro: AES_KEY_RELOAD_EN. When it is defined, the key is
// recaptured on every fetch. Otherwise the key from the first fetch of a run
// is held for the whole run.
module aes_block_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int TEXT_WIDTH  = 128,
  parameter int KEY_WIDTH   = 128,
  parameter int MEMORY_SIZE = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic [TEXT_WIDTH-1:0] plaintext_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic [TEXT_WIDTH-1:0] text_o,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_e;

  // Highest address that exists in the ROM; a requested end beyond it is pulled back.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEMORY_SIZE - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [TEXT_WIDTH-1:0] text_q, text_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;

  // State and datapath registers; reset returns everything to an idle, zeroed controller.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      text_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      text_q  <= text_d;
      key_q   <= key_d;
    end
  end

  // Next-state sequencing: one fetch cycle per block, then wait in ISSUE for the core.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = FETCH;
      FETCH:   state_d = ISSUE;
      ISSUE:   if (ready_i) state_d = (pc_q == last_q) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address walk and capture of the ROM read; pc stops at last so it never wraps.
  always_comb begin
    pc_d   = pc_q;
    last_d = last_q;
    text_d = text_q;
    key_d  = key_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pc_d   = '0;
          last_d = (last_addr_i > ADDR_MAX) ? ADDR_MAX : last_addr_i;
        end
      end
      FETCH: begin
        text_d = plaintext_i;
`ifdef AES_KEY_RELOAD_EN
        key_d = key_i;
`else
        if (pc_q == '0) key_d = key_i;
`endif
      end
      ISSUE: begin
        if (ready_i && (pc_q != last_q)) pc_d = pc_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Status outputs come only from the registered state, never from ready_i.
  always_comb begin
    valid_o = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE:    busy_o  = 1'b0;
      FETCH:   ;
      ISSUE:   valid_o = 1'b1;
      DONE:    done_o  = 1'b1;
      default: busy_o  = 1'b0;
    endcase
  end

  assign pc_o   = pc_q;
  assign text_o = text_q;
  assign key_o  = key_q;

endmodule

// File: tb/tb_aes_block_fetch_ctrl.sv
// tb_aes_block_fetch_ctrl
// Drives a full-depth controller (16 entries) and a clamped one (8 entries) from
// the same start/last/ready stimulus. Each one reads its own view of a shared
// ROM image, and both are compared every cycle against a run-level model.
module tb_aes_block_fetch_ctrl;

  localparam int AW  = 4;
  localparam int TW  = 128;
  localparam int KW  = 128;
  localparam int MS0 = 16;
  localparam int MS1 = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          ready;
  logic [AW-1:0] last_addr;

  logic [AW-1:0] pc     [2];
  logic [TW-1:0] text   [2];
  logic [TW-1:0] pt_in  [2];
  logic [KW-1:0] key    [2];
  logic [KW-1:0] key_in [2];
  logic          valid  [2];
  logic          busy   [2];
  logic          done   [2];

  logic [TW-1:0] mem_text [16];
  logic [KW-1:0] mem_key  [16];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  assign pt_in[0]  = mem_text[pc[0]];
  assign key_in[0] = mem_key[pc[0]];
  assign pt_in[1]  = mem_text[pc[1]];
  assign key_in[1] = mem_key[pc[1]];

  aes_block_fetch_ctrl #(.ADDR_WIDTH(AW), .TEXT_WIDTH(TW), .KEY_WIDTH(KW), .MEMORY_SIZE(MS0)) dut (
    .clock(clock), .reset(reset), .start_i(start), .last_addr_i(last_addr), .pc_o(pc[0]),
    .plaintext_i(pt_in[0]), .key_i(key_in[0]), .text_o(text[0]), .key_o(key[0]),
    .valid_o(valid[0]), .ready_i(ready), .busy_o(busy[0]), .done_o(done[0]));

  aes_block_fetch_ctrl #(.ADDR_WIDTH(AW), .TEXT_WIDTH(TW), .KEY_WIDTH(KW), .MEMORY_SIZE(MS1)) dut8 (
    .clock(clock), .reset(reset), .start_i(start), .last_addr_i(last_addr), .pc_o(pc[1]),
    .plaintext_i(pt_in[1]), .key_i(key_in[1]), .text_o(text[1]), .key_o(key[1]),
    .valid_o(valid[1]), .ready_i(ready), .busy_o(busy[1]), .done_o(done[1]));

  // Run-level model: a run is a block count plus the address on offer. A block
  // appears two edges after the start or the previous transfer. The cycle after
  // the final transfer is the done cycle.
  bit m_active [2];
  int m_cur    [2];
  int m_left   [2];
  int m_since  [2];

  function automatic int size_of(input int m);
    return (m == 0) ? MS0 : MS1;
  endfunction

  // Advance the model on every rising edge using only bench-driven inputs.
  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_active[m] = 1'b0;
        m_cur[m]    = 0;
        m_left[m]   = 0;
        m_since[m]  = 0;
      end else if (!m_active[m]) begin
        if (start) begin
          m_active[m] = 1'b1;
          m_cur[m]    = 0;
          m_left[m]   = ((int'(last_addr) < size_of(m)) ? int'(last_addr) : size_of(m) - 1) + 1;
          m_since[m]  = 1;
        end
      end else if (m_left[m] == 0) begin
        m_active[m] = 1'b0;
      end else if (m_since[m] >= 2 && ready) begin
        m_left[m]  = m_left[m] - 1;
        m_since[m] = 1;
        if (m_left[m] > 0) m_cur[m] = m_cur[m] + 1;
      end else if (m_since[m] < 2) begin
        m_since[m] = m_since[m] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare both controllers against the model on every falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        logic          ev;
        logic [KW-1:0] ek;
        ev = m_active[m] && (m_left[m] > 0) && (m_since[m] >= 2);
        checkOutput($sformatf("busy%0d", m), 128'(busy[m]), 128'(m_active[m]));
        checkOutput($sformatf("valid%0d", m), 128'(valid[m]), 128'(ev));
        checkOutput($sformatf("done%0d", m), 128'(done[m]), 128'(m_active[m] && (m_left[m] == 0)));
        checkOutput($sformatf("pc%0d", m), 128'(pc[m]), 128'(m_cur[m]));
        if (ev) begin
`ifdef AES_KEY_RELOAD_EN
          ek = mem_key[m_cur[m]];
`else
          ek = mem_key[0];
`endif
          checkOutput($sformatf("text%0d", m), text[m], mem_text[m_cur[m]]);
          checkOutput($sformatf("key%0d", m), key[m], ek);
        end
      end
    end
  end

  task automatic applyStimulus(input bit s, input logic [AW-1:0] la, input bit r);
    @(negedge clock);
    start     = s;
    last_addr = la;
    ready     = r;
  endtask

  task automatic randomizeRom();
    for (int i = 0; i < 16; i++) begin
      mem_text[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_key[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  int tr0, dn0, tr1, dn1, done_at, n_tr, held;
  int seq [16];
  bit ok;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    last_addr = '0;
    randomizeRom();
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    checkOutput("rst_pc", 128'(pc[0]), 128'd0);
    checkOutput("rst_text", text[0], 128'd0);
    checkOutput("rst_key", key[0], 128'd0);
    checkOutput("rst_valid", 128'(valid[0]), 128'd0);
    checkOutput("rst_busy", 128'(busy[0]), 128'd0);
    checkOutput("rst_done", 128'(done[0]), 128'd0);

    // Single block at address 0 with the core always ready.
    applyStimulus(1'b1, 4'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("single_fetch_valid", 128'(valid[0]), 128'd0);
    checkOutput("single_fetch_busy", 128'(busy[0]), 128'd1);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("single_issue_valid", 128'(valid[0]), 128'd1);
    checkOutput("single_issue_text", text[0], mem_text[0]);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("single_done", 128'(done[0]), 128'd1);
    checkOutput("single_pc", 128'(pc[0]), 128'd0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("single_after_done", 128'(done[0]), 128'd0);
    checkOutput("single_after_busy", 128'(busy[0]), 128'd0);

    // Full run to address 15 with stray starts; the 8-deep instance clamps to 7.
    applyStimulus(1'b1, 4'd15, 1'b1);
    tr0 = 0; dn0 = 0; tr1 = 0; dn1 = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus((c == 5) || (c == 12), 4'd15, 1'b1);
      if (valid[0]) tr0++;
      if (done[0]) begin dn0++; done_at = c; end
      if (valid[1]) tr1++;
      if (done[1]) dn1++;
    end
    checkOutput("full_transfers", 128'(tr0), 128'd16);
    checkOutput("full_done_count", 128'(dn0), 128'd1);
    checkOutput("full_done_cycle", 128'(done_at), 128'd33);
    checkOutput("full_busy_after", 128'(busy[0]), 128'd0);
    checkOutput("full_pc_after", 128'(pc[0]), 128'd15);
    checkOutput("clamp_transfers", 128'(tr1), 128'd8);
    checkOutput("clamp_done_count", 128'(dn1), 128'd1);
    checkOutput("clamp_pc_after", 128'(pc[1]), 128'd7);

    // Backpressure: hold ready low for five cycles while address 3 is on offer.
    applyStimulus(1'b1, 4'd6, 1'b1);
    n_tr = 0; held = 0;
    for (int c = 0; c < 60; c++) begin
      bit r;
      @(negedge clock);
      if (done[0]) break;
      start = 1'b0;
      r = 1'b1;
      if (valid[0] && (pc[0] == 4'd3) && (held < 5)) begin
        r = 1'b0;
        held++;
      end
      ready = r;
      if (valid[0] && r && (n_tr < 16)) begin
        seq[n_tr] = int'(pc[0]);
        n_tr++;
      end
    end
    checkOutput("bp_held_cycles", 128'(held), 128'd5);
    checkOutput("bp_transfers", 128'(n_tr), 128'd7);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("bp_order%0d", i), 128'(seq[i]), 128'(i));
    repeat (2) applyStimulus(1'b0, 4'd0, 1'b1);

    // Reset in the middle of ISSUE aborts the run without a done pulse.
    applyStimulus(1'b1, 4'd15, 1'b0);
    applyStimulus(1'b0, 4'd15, 1'b0);
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("midrst_valid_before", 128'(valid[0]), 128'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_done_during", 128'(done[0]), 128'd0);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst_valid", 128'(valid[0]), 128'd0);
    checkOutput("midrst_busy", 128'(busy[0]), 128'd0);
    checkOutput("midrst_pc", 128'(pc[0]), 128'd0);
    checkOutput("midrst_text", text[0], 128'd0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("midrst_no_done", 128'(done[0]), 128'd0);

    // Randomized runs with random backpressure, stray starts and rare resets.
    for (int run = 0; run < 30; run++) begin
      randomizeRom();
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clock);
        if (!busy[0] && !busy[1]) begin
          ok = 1'b1;
          break;
        end
        start     = busy[0] && busy[1] && ($urandom_range(0, 7) == 0);
        last_addr = 4'($urandom_range(0, 15));
        ready     = ($urandom_range(0, 3) != 0);
        reset     = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
      start = 1'b0;
      checkOutput($sformatf("run%0d_reaches_idle", run), 128'(ok), 128'd1);
      @(negedge clock);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
